// File: rtl/native_mem_axi_bridge_if.sv
// native_mem_axi_bridge_if: native memory request port plus AXI4-Lite master channels
interface native_mem_axi_bridge_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  // bridge view: serves the native request, masters the AXI channels
  modport master (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_awready,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_wready,
    input  mem_axi_bvalid,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    input  mem_axi_arready,
    input  mem_axi_rvalid, mem_axi_rdata,
    output mem_axi_rready
  );

  // environment view: the CPU issuing requests and the AXI memory answering them
  modport slave (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_awready,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_wready,
    output mem_axi_bvalid,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    output mem_axi_arready,
    output mem_axi_rvalid, mem_axi_rdata,
    input  mem_axi_rready
  );
endinterface

// File: rtl/native_mem_axi_bridge.sv
// native_mem_axi_bridge: one-outstanding native memory port to AXI4-Lite master with wait-state watchdog
module native_mem_axi_bridge #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    resetn,
  native_mem_axi_bridge_if.master bus,
  output logic                    bus_error
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] cnt;
    logic [3:0]  wstrb;
    logic        instr;
    logic        ready;
    logic        awvalid;
    logic        wvalid;
    logic        bready;
    logic        arvalid;
    logic        rready;
    logic        aw_done;
    logic        w_done;
    logic        dropped;
    logic        error;
  } regs_t;
  localparam logic [31:0] LIMIT = 32'(TIMEOUT);
  state_t state, state_n;
  regs_t r, n;
  logic waiting, gone;
  assign waiting = state inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP};
  // once the requester lets go of mem_valid the transaction is orphaned for good
  assign gone = r.dropped | ~bus.mem_valid;
  // next state plus next image of every register; outputs come straight from the register image
  always_comb begin
    state_n = state;
    n = r;
    n.dropped = waiting ? gone : r.dropped;
    case (state)
      IDLE: if (bus.mem_valid) begin
        state_n = |bus.mem_wstrb ? WR_REQ : RD_ADDR;
        n.addr = bus.mem_addr;
        n.wdata = bus.mem_wdata;
        n.wstrb = bus.mem_wstrb;
        n.instr = bus.mem_instr;
        n.arvalid = ~|bus.mem_wstrb;
        n.awvalid = |bus.mem_wstrb;
        n.wvalid = |bus.mem_wstrb;
        n.aw_done = 1'b0;
        n.w_done = 1'b0;
        n.dropped = 1'b0;
      end
      RD_ADDR: if (r.arvalid && bus.mem_axi_arready) begin
        n.arvalid = 1'b0;
        n.rready = 1'b1;
        state_n = RD_DATA;
      end
      RD_DATA: if (r.rready && bus.mem_axi_rvalid) begin
        n.rdata = bus.mem_axi_rdata;
        n.rready = 1'b0;
        n.ready = ~gone;
        state_n = DONE;
      end
      WR_REQ: begin
        n.aw_done = r.aw_done | (r.awvalid & bus.mem_axi_awready);
        n.w_done = r.w_done | (r.wvalid & bus.mem_axi_wready);
        n.awvalid = r.awvalid & ~bus.mem_axi_awready;
        n.wvalid = r.wvalid & ~bus.mem_axi_wready;
        if (n.aw_done && n.w_done) begin
          n.bready = 1'b1;
          state_n = WR_RESP;
        end
      end
      WR_RESP: if (r.bready && bus.mem_axi_bvalid) begin
        n.bready = 1'b0;
        n.ready = ~gone;
        state_n = DONE;
      end
      DONE: begin
        n.ready = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    n.cnt = state_n == DONE ? '0 : waiting && r.cnt != LIMIT ? r.cnt + 32'd1 : r.cnt;
    n.error = r.error | (LIMIT != '0 && waiting && n.cnt == LIMIT);
  end
  // state and register image, cleared asynchronously
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      r <= '0;
    end else begin
      state <= state_n;
      r <= n;
    end
  assign bus.mem_ready = r.ready;
  assign bus.mem_rdata = r.rdata;
  assign bus.mem_axi_awvalid = r.awvalid;
  assign bus.mem_axi_awaddr = r.addr;
  assign bus.mem_axi_awprot = {r.instr, 2'b00};
  assign bus.mem_axi_wvalid = r.wvalid;
  assign bus.mem_axi_wdata = r.wdata;
  assign bus.mem_axi_wstrb = r.wstrb;
  assign bus.mem_axi_bready = r.bready;
  assign bus.mem_axi_arvalid = r.arvalid;
  assign bus.mem_axi_araddr = r.addr;
  assign bus.mem_axi_arprot = {r.instr, 2'b00};
  assign bus.mem_axi_rready = r.rready;
  assign bus_error = r.error;
endmodule

// File: tb/tb_native_mem_axi_bridge.sv
// tb_native_mem_axi_bridge: randomized bench for the native-to-AXI4-Lite bridge against a transaction-level model
module tb_native_mem_axi_bridge;
  logic clk = 1'b0;
  logic resetn;
  logic bus_error;
  native_mem_axi_bridge_if bus();
  native_mem_axi_bridge #(.TIMEOUT(8)) dut (.clk(clk), .resetn(resetn), .bus(bus), .bus_error(bus_error));
  always #5 clk = ~clk;

  int compared = 0, mismatched = 0;
  int ar_wait, r_wait, aw_wait, w_wait, b_wait;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit rd_busy, aw_got, w_got, ar_pend, aw_pend, w_pend;
  logic [31:0] rd_addr, wr_addr, wr_data, ar_prev, aw_prev, w_prev;
  logic [3:0] wr_strb, ws_prev;
  logic [2:0] ar_prot, aw_prot;
  int ar_hs = 0, aw_hs = 0, b_hs = 0, pulses = 0;
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_rd;
  int exp_txn = 0, exp_wr = 0, exp_pulses = 0, first_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
    return old;
  endfunction

  // AXI4-Lite memory with programmable wait states; also watches valid stability and counts handshakes
  always @(negedge clk) begin
    if (!resetn) begin
      bus.mem_axi_arready = 1'b0;
      bus.mem_axi_rvalid = 1'b0;
      bus.mem_axi_rdata = '0;
      bus.mem_axi_awready = 1'b0;
      bus.mem_axi_wready = 1'b0;
      bus.mem_axi_bvalid = 1'b0;
      rd_busy = 0; aw_got = 0; w_got = 0; ar_pend = 0; aw_pend = 0; w_pend = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (bus.mem_ready) pulses++;
      if (ar_pend) begin
        check("ar_hold", bus.mem_axi_arvalid, 1);
        check("ar_stable", bus.mem_axi_araddr, ar_prev);
      end
      if (aw_pend) begin
        check("aw_hold", bus.mem_axi_awvalid, 1);
        check("aw_stable", bus.mem_axi_awaddr, aw_prev);
      end
      if (w_pend) begin
        check("w_hold", bus.mem_axi_wvalid, 1);
        check("w_stable", bus.mem_axi_wdata, w_prev);
        check("wstrb_stable", bus.mem_axi_wstrb, ws_prev);
      end
      if (aw_got && w_got) begin
        if (b_cnt == b_wait) begin
          bus.mem_axi_bvalid = 1'b1;
          if (bus.mem_axi_bready) begin
            slv_mem[wr_addr] = merge(slv_mem.exists(wr_addr) ? slv_mem[wr_addr] : '0, wr_data, wr_strb);
            b_hs++; aw_got = 0; w_got = 0; b_cnt = 0;
          end
        end else begin
          bus.mem_axi_bvalid = 1'b0;
          b_cnt++;
        end
      end else bus.mem_axi_bvalid = 1'b0;
      if (rd_busy) begin
        if (r_cnt == r_wait) begin
          bus.mem_axi_rvalid = 1'b1;
          bus.mem_axi_rdata = slv_mem.exists(rd_addr) ? slv_mem[rd_addr] : '0;
          if (bus.mem_axi_rready) begin rd_busy = 0; r_cnt = 0; end
        end else begin
          bus.mem_axi_rvalid = 1'b0;
          r_cnt++;
        end
      end else bus.mem_axi_rvalid = 1'b0;
      ar_pend = 0;
      if (bus.mem_axi_arvalid) begin
        if (ar_cnt == ar_wait) begin
          bus.mem_axi_arready = 1'b1;
          rd_busy = 1; rd_addr = bus.mem_axi_araddr; ar_prot = bus.mem_axi_arprot; ar_hs++; ar_cnt = 0;
        end else begin
          bus.mem_axi_arready = 1'b0;
          ar_cnt++; ar_pend = 1; ar_prev = bus.mem_axi_araddr;
        end
      end else bus.mem_axi_arready = 1'b0;
      aw_pend = 0;
      if (bus.mem_axi_awvalid) begin
        if (aw_cnt == aw_wait) begin
          bus.mem_axi_awready = 1'b1;
          aw_got = 1; wr_addr = bus.mem_axi_awaddr; aw_prot = bus.mem_axi_awprot; aw_hs++; aw_cnt = 0;
        end else begin
          bus.mem_axi_awready = 1'b0;
          aw_cnt++; aw_pend = 1; aw_prev = bus.mem_axi_awaddr;
        end
      end else bus.mem_axi_awready = 1'b0;
      w_pend = 0;
      if (bus.mem_axi_wvalid) begin
        if (w_cnt == w_wait) begin
          bus.mem_axi_wready = 1'b1;
          w_got = 1; wr_data = bus.mem_axi_wdata; wr_strb = bus.mem_axi_wstrb; w_cnt = 0;
        end else begin
          bus.mem_axi_wready = 1'b0;
          w_cnt++; w_pend = 1; w_prev = bus.mem_axi_wdata; ws_prev = bus.mem_axi_wstrb;
        end
      end else bus.mem_axi_wready = 1'b0;
    end
  end

  // one native transaction from a negedge; latency = 3 cycles plus slave waits (writes: slower of AW/W plus B)
  task automatic do_req(input string tag, input bit instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int ar_w, input int r_w, input int aw_w, input int w_w, input int b_w);
    int n = 0;
    int lat;
    logic [31:0] exp;
    ar_wait = ar_w; r_wait = r_w; aw_wait = aw_w; w_wait = w_w; b_wait = b_w;
    lat = strb == 0 ? 3 + ar_w + r_w : 3 + (aw_w > w_w ? aw_w : w_w) + b_w;
    exp = ref_mem.exists(addr) ? ref_mem[addr] : '0;
    bus.mem_valid = 1'b1; bus.mem_instr = instr; bus.mem_addr = addr; bus.mem_wdata = wdata; bus.mem_wstrb = strb;
    first_err = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (bus_error && first_err == 0) first_err = n;
    end while (!bus.mem_ready && n < 100);
    check({tag, "_latency"}, n, lat);
    if (strb == 0) begin
      check({tag, "_rdata"}, bus.mem_rdata, exp);
      last_rd = exp;
      check({tag, "_araddr"}, rd_addr, addr);
      check({tag, "_arprot"}, ar_prot, {instr, 2'b00});
    end else begin
      check({tag, "_rdata_hold"}, bus.mem_rdata, last_rd);
      check({tag, "_awaddr"}, wr_addr, addr);
      check({tag, "_awprot"}, aw_prot, {instr, 2'b00});
      check({tag, "_wdata"}, wr_data, wdata);
      check({tag, "_wstrb"}, wr_strb, strb);
      ref_mem[addr] = merge(exp, wdata, strb);
      exp_wr++;
    end
    exp_txn++;
    exp_pulses++;
    @(posedge clk); #1;
    check({tag, "_one_pulse"}, bus.mem_ready, 0);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    bus.mem_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int t0, p0, b0;
    logic [31:0] a, d, v;
    logic [3:0] s;
    resetn = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    last_rd = '0;
    for (int i = 0; i < 16; i++) begin
      v = i == 4 ? 32'h1234_5678 : $urandom;
      slv_mem[32'(i) << 2] = v;
      ref_mem[32'(i) << 2] = v;
    end
    repeat (3) @(negedge clk);
    check("rst_mem_ready", bus.mem_ready, 0);
    check("rst_arvalid", bus.mem_axi_arvalid, 0);
    check("rst_awvalid", bus.mem_axi_awvalid, 0);
    check("rst_wvalid", bus.mem_axi_wvalid, 0);
    check("rst_bready", bus.mem_axi_bready, 0);
    check("rst_rready", bus.mem_axi_rready, 0);
    check("rst_rdata", bus.mem_rdata, 0);
    check("rst_araddr", bus.mem_axi_araddr, 0);
    check("rst_bus_error", bus_error, 0);
    resetn = 1'b1;
    @(negedge clk);

    do_req("fetch", 1'b1, 32'h10, 32'h0, 4'b0000, 0, 0, 0, 0, 0);
    check("fetch_const", bus.mem_rdata, 32'h1234_5678);

    b0 = b_hs;
    do_req("wr_a5", 1'b0, 32'h4000_0000, 32'hA5A5_A5A5, 4'b0011, 0, 0, 0, 0, 0);
    check("wr_a5_b_count", b_hs - b0, 1);
    do_req("rd_a5", 1'b0, 32'h4000_0000, 32'h0, 4'b0000, 0, 0, 0, 0, 0);
    check("rd_a5_const", bus.mem_rdata, 32'h0000_A5A5);

    p0 = pulses;
    do_req("w_first", 1'b0, 32'h20, $urandom, 4'b1111, 0, 0, 3, 0, 0);
    do_req("aw_first", 1'b0, 32'h24, $urandom, 4'b1100, 0, 0, 0, 3, 0);
    check("order_pulses", pulses - p0, 2);

    t0 = ar_hs + aw_hs; p0 = pulses;
    do_req("b2b_rd", 1'b0, 32'h20, 32'h0, 4'b0000, 0, 0, 0, 0, 0);
    do_req("b2b_wr", 1'b0, 32'h28, $urandom, 4'b0101, 0, 0, 0, 0, 0);
    idle(3);
    check("b2b_txn", ar_hs + aw_hs - t0, 2);
    check("b2b_pulses", pulses - p0, 2);

    for (int k = 0; k < 40; k++) begin
      a = ($urandom_range(0, 1) ? 32'h4000_0000 : 32'h0) | (32'($urandom_range(0, 15)) << 2);
      d = $urandom;
      s = $urandom_range(0, 1) ? 4'(($urandom_range(1, 15))) : 4'b0000;
      do_req($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    check("no_timeout", bus_error, 0);

    t0 = ar_hs; p0 = pulses;
    ar_wait = 3; r_wait = 1;
    bus.mem_valid = 1'b1; bus.mem_instr = 1'b0; bus.mem_addr = 32'h8; bus.mem_wstrb = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("abandon_ar", ar_hs - t0, 1);
    check("abandon_pulse", pulses - p0, 0);
    last_rd = ref_mem[32'h8];
    check("abandon_rdata", bus.mem_rdata, last_rd);
    exp_txn++;

    do_req("timeout", 1'b0, 32'h14, 32'h0, 4'b0000, 20, 0, 0, 0, 0);
    check("err_first_cycle", first_err, 9);
    check("err_sticky", bus_error, 1);

    aw_wait = 5; w_wait = 5; b_wait = 0;
    bus.mem_valid = 1'b1; bus.mem_instr = 1'b0; bus.mem_addr = 32'h18; bus.mem_wdata = $urandom; bus.mem_wstrb = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_awvalid", bus.mem_axi_awvalid, 1);
    bus.mem_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check("mid_rst_awvalid", bus.mem_axi_awvalid, 0);
    check("mid_rst_wvalid", bus.mem_axi_wvalid, 0);
    check("mid_rst_bready", bus.mem_axi_bready, 0);
    check("mid_rst_arvalid", bus.mem_axi_arvalid, 0);
    check("mid_rst_rready", bus.mem_axi_rready, 0);
    check("mid_rst_mem_ready", bus.mem_ready, 0);
    check("mid_rst_bus_error", bus_error, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    last_rd = '0;
    check("mid_rst_rdata", bus.mem_rdata, 0);
    @(negedge clk);
    do_req("post_rst", 1'b1, 32'h10, 32'h0, 4'b0000, 1, 1, 0, 0, 0);
    idle(2);

    check("txn_count", ar_hs + aw_hs, exp_txn);
    check("b_count", b_hs, exp_wr);
    check("pulse_count", pulses, exp_pulses);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/native_mem_axi_bridge.md
# native_mem_axi_bridge

Bridge that turns the core's native memory request interface (valid/ready, one outstanding access) into AXI4-Lite master transactions for the `axi4_mem_periph` memory/peripheral model. It sits directly upstream of that model: the CPU drives the native side, and the AXI side connects port-for-port to the `mem_axi_*` signals. It also carries a wait-state watchdog that flags stalled transactions for the testbench.

## Interface
Parameters:
- `TIMEOUT`, default 1024: watchdog limit in cycles spent in any AXI wait state; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  native request valid.
- `mem_instr`  in  1  request is an instruction fetch.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte enables; 0 means read.
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1.
- `mem_axi_awvalid`  out  1; `mem_axi_awready`  in  1; `mem_axi_awaddr`  out  32; `mem_axi_awprot`  out  3.
- `mem_axi_wvalid`  out  1; `mem_axi_wready`  in  1; `mem_axi_wdata`  out  32; `mem_axi_wstrb`  out  4.
- `mem_axi_bvalid`  in  1; `mem_axi_bready`  out  1.
- `mem_axi_arvalid`  out  1; `mem_axi_arready`  in  1; `mem_axi_araddr`  out  32; `mem_axi_arprot`  out  3.
- `mem_axi_rvalid`  in  1; `mem_axi_rready`  out  1; `mem_axi_rdata`  in  32.
- `bus_error`  out  1  sticky; the watchdog expired at least once since reset.

## Operation
- Every output is registered.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - `mem_valid`=1 and `mem_wstrb`=0 → RD_ADDR.
  - `mem_valid`=1 and `mem_wstrb`≠0 → WR_REQ.
  - On entry to either state, latch addr, wdata, wstrb and instr.
- prot encoding: `{instr,2'b00}` on both `awprot` and `arprot` (3'b100 for a fetch, 3'b000 for data).
- RD_ADDR:
  - `arvalid`=1 with `araddr`=latched addr.
  - On sampling `arvalid`&&`arready`: `arvalid`←0, `rready`←1, go to RD_DATA.
- RD_DATA:
  - On `rvalid`&&`rready`: `mem_rdata`←`mem_axi_rdata`, `rready`←0, `mem_ready`←1, go to DONE.
- WR_REQ:
  - `awvalid` and `wvalid` rise together.
  - Each drops independently after its own handshake; flags `aw_done` and `w_done` record completion.
  - AW and W may complete in either order or in the same cycle.
  - Once both flags are set (including a same-edge completion): `bready`←1, go to WR_RESP.
- WR_RESP: on `bvalid`&&`bready`: `bready`←0, `mem_ready`←1, go to DONE.
- DONE: `mem_ready`←0, go to IDLE. The request still on `mem_valid` during DONE is never re-sampled.
- `mem_rdata` holds its last read value after writes; it is not updated on a write completion.
- If `mem_valid` drops mid-transaction:
  - The AXI transaction still completes; AXI valid signals are never withdrawn before their handshake.
  - The `mem_ready` pulse for that transaction is suppressed.
- Watchdog:
  - A counter increments every cycle in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - It clears on entry to DONE.
  - When the count reaches `TIMEOUT` (`TIMEOUT`≠0), `bus_error`←1. The counter saturates, and the transaction keeps waiting and is not aborted.
  - `bus_error` clears only on reset.
- Reset (asynchronous, any state, including mid-transaction):
  - State returns to IDLE.
  - All valid/ready outputs, `mem_ready`, `bus_error`, the counter and the done flags go to 0.
  - `mem_rdata` and all address/data outputs go to 0.

## Timing
- Edges are numbered E0 (request sampled in IDLE), E1, E2, ...
- Read with a zero-wait slave:
  - `arvalid` is high after E0.
  - The AR handshake is sampled at E1; `rready` is high after E1.
  - R is sampled at E2; `mem_ready` is high for the single cycle after E2.
  - A new request is sampled no earlier than E4.
- Write with a zero-wait slave:
  - AW and W are both handshaken at E1.
  - `bready` is high after E1; B is sampled at E2; `mem_ready` pulses after E2.
- Each slave wait cycle adds exactly one cycle.
- `rready`=1 only in RD_DATA; `bready`=1 only in WR_RESP.
- At most one outstanding transaction at any time.
- Address/data outputs are stable while the corresponding valid is high.

## Test plan
- Read, addr 0x0000_0010, slave preloaded 0x1234_5678, `mem_instr`=1 → `araddr`=0x10, `arprot`=3'b100; `mem_rdata`=0x1234_5678 with one-cycle `mem_ready` at E2.
- Write 0xA5A5_A5A5, wstrb 4'b0011, addr 0x4000_0000 → `awaddr`/`wdata`/`wstrb` match; a later read of the same address returns 0x0000_A5A5; exactly one `bready` handshake.
- Write with W accepted 3 cycles before AW, then the reverse order → both orders complete; each valid drops only after its own handshake; one `mem_ready` each.
- Zero-wait slave, read followed by a back-to-back write → no duplicate transaction from `mem_valid` still high during DONE; AXI transaction count = 2.
- `TIMEOUT`=8 with `arready` held low 20 cycles → `bus_error` rises after 8 wait cycles and stays high; the read still completes once `arready` rises.
- `resetn` pulsed low while in WR_REQ → all AXI valid/ready outputs and `mem_ready` go to 0 immediately; the next read after reset works normally.
